// File: rtl/hbus_pkg.sv
// Shared types and constants for the Wishbone-to-HyperBus bridge.
package hbus_pkg;

  localparam int unsigned HB_DW = 16;
  localparam int unsigned HB_MW = HB_DW / 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ_LO,
    WAIT_LO,
    REQ_HI,
    WAIT_HI,
    ACK
  } state_e;

endpackage

// File: rtl/hbus_req_seq.sv
// One-half request/wait handshake towards the hyperbus controller.
// The parent FSM says when it is requesting or waiting; this block turns that
// into wrq/rrq pulses, a completion flag and (with HBUS_BRIDGE_TIMEOUT_EN) a
// timeout flag.
module hbus_req_seq
  import hbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic req_en,
  input  logic wait_en,
  input  logic we,
  input  logic ready,
  input  logic valid,
  output logic wrq,
  output logic rrq,
  output logic issued,
  output logic done,
  output logic timeout
);

  // Issue only while the controller is idle; completion is valid while waiting.
  always_comb begin
    issued = req_en & ready;
    wrq    = issued & we;
    rrq    = issued & ~we;
    done   = wait_en & valid;
  end

`ifdef HBUS_BRIDGE_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;

  // Counter restarts whenever the parent is not waiting, so it is 0 on WAIT entry.
  always_comb begin
    cnt_d = '0;
    if (wait_en && !valid) begin
      cnt_d = cnt_q + 32'd1;
    end
    timeout = wait_en & ~valid & (cnt_q == 32'(TIMEOUT_CYCLES - 1));
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [32:0] unused_seq;

  // Without the timeout feature a wait never expires.
  always_comb begin
    timeout    = 1'b0;
    unused_seq = {clk | rst, 32'(TIMEOUT_CYCLES)};
  end
`endif

endmodule

// File: rtl/hbus_wb_bridge.sv
// Wishbone classic 32-bit slave feeding the hyperbus request port.
// Each access is split into up to two 16-bit controller transactions, low half
// first; halves with no byte selects are skipped.
// Optional feature macro: HBUS_BRIDGE_TIMEOUT_EN (per-transaction timeout, wb_err_o).
module hbus_wb_bridge
  import hbus_pkg::*;
#(
  parameter int unsigned REG_SPACE_BIT  = 31,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] hb_adr_o,
  output logic [15:0] hb_dat_o,
  input  logic [15:0] hb_dat_i,
  output logic [1:0]  hb_mask_o,
  output logic        hb_reg_space_o,
  output logic        hb_wrq_o,
  output logic        hb_rrq_o,
  input  logic        hb_ready_i,
  input  logic        hb_valid_i
);

  state_e      state_q, state_d;
  logic [29:0] wadr_q, wadr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        rs_q, rs_d;
  logic [31:0] rdat_q, rdat_d;

  logic [31:0]      a_clr;
  logic [1:0]       unused_adr_lsb;
  logic             busy, hi, req_en, wait_en;
  logic [HB_MW-1:0] half_sel;
  logic             seq_issued, seq_done, seq_timeout;

  hbus_req_seq #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .req_en  (req_en),
    .wait_en (wait_en),
    .we      (we_q),
    .ready   (hb_ready_i),
    .valid   (hb_valid_i),
    .wrq     (hb_wrq_o),
    .rrq     (hb_rrq_o),
    .issued  (seq_issued),
    .done    (seq_done),
    .timeout (seq_timeout)
  );

  // Address with the register-space bit cleared; byte offset bits are dropped.
  always_comb begin
    a_clr          = wb_adr_i & ~(32'd1 << REG_SPACE_BIT);
    unused_adr_lsb = a_clr[1:0];
  end

  // Next-state and latch logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    wadr_d  = wadr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rs_d    = rs_q;
    rdat_d  = rdat_q;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          wadr_d = a_clr[31:2];
          wdat_d = wb_dat_i;
          sel_d  = wb_sel_i;
          we_d   = wb_we_i;
          rs_d   = wb_adr_i[REG_SPACE_BIT];
          if (!wb_we_i) begin
            rdat_d = '0;
          end
          if (wb_sel_i == 4'b0000) begin
            state_d = ACK;
          end else if (wb_sel_i[1:0] != 2'b00) begin
            state_d = REQ_LO;
          end else begin
            state_d = REQ_HI;
          end
        end
      end
      REQ_LO: begin
        if (seq_issued) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (seq_done) begin
          if (!we_q) begin
            rdat_d[HB_DW-1:0] = hb_dat_i;
          end
          state_d = (sel_q[3:2] != 2'b00) ? REQ_HI : ACK;
        end else if (seq_timeout) begin
          state_d = IDLE;
        end
      end
      REQ_HI: begin
        if (seq_issued) begin
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (seq_done) begin
          if (!we_q) begin
            rdat_d[2*HB_DW-1:HB_DW] = hb_dat_i;
          end
          state_d = ACK;
        end else if (seq_timeout) begin
          state_d = IDLE;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and latched access registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wadr_q  <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rs_q    <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      wadr_q  <= wadr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rs_q    <= rs_d;
      rdat_q  <= rdat_d;
    end
  end

  // Controller-side outputs are driven only while a half is in flight.
  always_comb begin
    req_en   = (state_q == REQ_LO) || (state_q == REQ_HI);
    wait_en  = (state_q == WAIT_LO) || (state_q == WAIT_HI);
    busy     = req_en | wait_en;
    hi       = (state_q == REQ_HI) || (state_q == WAIT_HI);
    half_sel = hi ? sel_q[3:2] : sel_q[1:0];

    hb_adr_o       = busy ? {1'b0, wadr_q, hi} : '0;
    hb_dat_o       = busy ? (hi ? wdat_q[2*HB_DW-1:HB_DW] : wdat_q[HB_DW-1:0]) : '0;
    hb_mask_o      = busy ? ~half_sel : '0;
    hb_reg_space_o = busy & rs_q;

    wb_dat_o = rdat_q;
    wb_ack_o = (state_q == ACK) & wb_cyc_i;
    wb_err_o = seq_timeout & wb_cyc_i;
  end

endmodule

// File: tb/tb_hbus_wb_bridge.sv
// Scoreboard bench for hbus_wb_bridge: stimulus pushes expected controller
// requests and Wishbone responses; a monitor pops and compares them.
module tb_hbus_wb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] hb_adr_o;
  logic [15:0] hb_dat_o, hb_dat_i;
  logic [1:0]  hb_mask_o;
  logic        hb_reg_space_o, hb_wrq_o, hb_rrq_o, hb_ready_i, hb_valid_i;

  hbus_wb_bridge #(
    .REG_SPACE_BIT (31),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_adr_i       (wb_adr_i),
    .wb_dat_i       (wb_dat_i),
    .wb_sel_i       (wb_sel_i),
    .wb_we_i        (wb_we_i),
    .wb_cyc_i       (wb_cyc_i),
    .wb_stb_i       (wb_stb_i),
    .wb_dat_o       (wb_dat_o),
    .wb_ack_o       (wb_ack_o),
    .wb_err_o       (wb_err_o),
    .hb_adr_o       (hb_adr_o),
    .hb_dat_o       (hb_dat_o),
    .hb_dat_i       (hb_dat_i),
    .hb_mask_o      (hb_mask_o),
    .hb_reg_space_o (hb_reg_space_o),
    .hb_wrq_o       (hb_wrq_o),
    .hb_rrq_o       (hb_rrq_o),
    .hb_ready_i     (hb_ready_i),
    .hb_valid_i     (hb_valid_i)
  );

  always #5 clk = ~clk;

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  mask;
    logic        rs;
  } req_t;

  typedef struct {
    logic        is_err;
    logic [31:0] dat;
  } rsp_t;

  req_t        exp_req_q[$];
  rsp_t        exp_rsp_q[$];
  logic [15:0] rd_q[$];
  int unsigned req_cyc_log[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_req = 0, n_rrq = 0, n_ack = 0, n_err = 0;
  int unsigned last_req_cyc = 0, last_valid_cyc = 0, last_ack_cyc = 0, last_err_cyc = 0;
  int unsigned stb_cyc = 0;

  int   ctrl_lat = 0;
  int   withhold_after = -1;
  logic ctrl_busy = 1'b0;
  logic hold_ready = 1'b0;
  assign hb_ready_i = !ctrl_busy && !hold_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void push_req(input logic we, input logic [31:0] adr, input logic [15:0] dat,
                                   input logic [1:0] mask, input logic rs);
    req_t e;
    e.we = we; e.adr = adr; e.dat = dat; e.mask = mask; e.rs = rs;
    exp_req_q.push_back(e);
  endfunction

  function automatic void push_rsp(input logic is_err, input logic [31:0] dat);
    rsp_t r;
    r.is_err = is_err; r.dat = dat;
    exp_rsp_q.push_back(r);
  endfunction

  task automatic check_all_zero(input string name);
    check({name, "_wb_dat"}, wb_dat_o, 32'h0);
    check({name, "_hb_adr"}, hb_adr_o, 32'h0);
    check({name, "_hb_dat"}, {16'h0, hb_dat_o}, 32'h0);
    check({name, "_flags"}, {24'h0, wb_ack_o, wb_err_o, hb_wrq_o, hb_rrq_o, hb_reg_space_o, hb_mask_o, 1'b0}, 32'h0);
  endtask

  task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    @(posedge clk); #1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    stb_cyc  = cyc_n;
  endtask

  task automatic wb_finish(input string name);
    logic got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    check({name, "_terminated"}, {31'h0, got}, 32'h1);
  endtask

  task automatic wait_reqs(input int target, input string name);
    int i = 0;
    while (n_req < target && i < 300) begin
      @(negedge clk);
      i++;
    end
    check({name, "_req_count"}, n_req, target);
  endtask

  // Controller model: one request at a time, valid after ctrl_lat extra cycles.
  initial begin
    logic rd;
    hb_valid_i = 1'b0;
    hb_dat_i   = '0;
    forever begin
      @(negedge clk);
      if (!rst && (hb_wrq_o || hb_rrq_o)) begin
        rd = hb_rrq_o;
        @(posedge clk); #1;
        ctrl_busy = 1'b1;
        if (withhold_after == 0) begin
          wait (withhold_after != 0);
        end else begin
          if (withhold_after > 0) withhold_after--;
          repeat (ctrl_lat) begin
            @(posedge clk); #1;
          end
          hb_valid_i = 1'b1;
          if (rd && rd_q.size() > 0) hb_dat_i = rd_q.pop_front();
          else hb_dat_i = 16'h0;
          @(posedge clk); #1;
          hb_valid_i = 1'b0;
          hb_dat_i   = '0;
        end
        ctrl_busy = 1'b0;
      end
    end
  end

  // Monitor: compare every request and every Wishbone termination against the queues.
  initial begin
    req_t        e;
    rsp_t        r;
    logic [31:0] cur_adr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hb_wrq_o || hb_rrq_o) begin
          check("req_exclusive", {31'h0, hb_wrq_o & hb_rrq_o}, 32'h0);
          n_req++;
          if (hb_rrq_o) n_rrq++;
          last_req_cyc = cyc_n;
          req_cyc_log.push_back(cyc_n);
          cur_adr = hb_adr_o;
          if (exp_req_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_request: got adr 0x%08h, no request expected", hb_adr_o);
          end else begin
            e = exp_req_q.pop_front();
            check("req_we", {31'h0, hb_wrq_o}, {31'h0, e.we});
            check("req_adr", hb_adr_o, e.adr);
            check("req_mask", {30'h0, hb_mask_o}, {30'h0, e.mask});
            check("req_reg_space", {31'h0, hb_reg_space_o}, {31'h0, e.rs});
            if (e.we) check("req_dat", {16'h0, hb_dat_o}, {16'h0, e.dat});
          end
        end
        if (hb_valid_i) begin
          last_valid_cyc = cyc_n;
          check("adr_hold_until_valid", hb_adr_o, cur_adr);
        end
        if (wb_ack_o || wb_err_o) begin
          if (wb_ack_o) begin n_ack++; last_ack_cyc = cyc_n; end
          if (wb_err_o) begin n_err++; last_err_cyc = cyc_n; end
          if (exp_rsp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_response: got ack=%0b err=%0b, no response expected", wb_ack_o, wb_err_o);
          end else begin
            r = exp_rsp_q.pop_front();
            check("rsp_is_err", {31'h0, wb_err_o}, {31'h0, r.is_err});
            check("rsp_ack", {31'h0, wb_ack_o}, {31'h0, ~r.is_err});
            if (!r.is_err) check("rsp_dat", wb_dat_o, r.dat);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base_ack, base_err;
    int unsigned rise_cyc;
    rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Full-word write: low half at W, high half at W+1, ack one cycle after last valid.
    base = n_req;
    req_cyc_log.delete();
    push_req(1'b1, 32'h8, 16'hBEEF, 2'b00, 1'b0);
    push_req(1'b1, 32'h9, 16'hDEAD, 2'b00, 1'b0);
    push_rsp(1'b0, 32'h0);
    wb_start(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    wb_finish("wr_full");
    check("wr_full_nreq", n_req - base, 2);
    check("wr_full_req_latency", req_cyc_log[0] - stb_cyc, 1);
    check("wr_full_ack_latency", last_ack_cyc - last_valid_cyc, 1);

    // Full-word read with a slower controller.
    ctrl_lat = 2;
    base = n_rrq;
    rd_q.push_back(16'h1234);
    rd_q.push_back(16'h5678);
    push_req(1'b0, 32'h8, 16'h0, 2'b00, 1'b0);
    push_req(1'b0, 32'h9, 16'h0, 2'b00, 1'b0);
    push_rsp(1'b0, 32'h5678_1234);
    wb_start(1'b0, 32'h0000_0010, 32'h0, 4'b1111);
    wb_finish("rd_full");
    check("rd_full_nrrq", n_rrq - base, 2);
    ctrl_lat = 0;

    // High-half write in register space: A=0x4 -> W=2, high half at 3.
    push_req(1'b1, 32'h3, 16'hCAFE, 2'b00, 1'b1);
    push_rsp(1'b0, 32'h5678_1234);
    wb_start(1'b1, 32'h8000_0004, 32'hCAFE_0000, 4'b1100);
    wb_finish("wr_hi_regspace");

    // Single-byte write in the low half: mask 01.
    push_req(1'b1, 32'h10, 16'hAB00, 2'b01, 1'b0);
    push_rsp(1'b0, 32'h5678_1234);
    wb_start(1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010);
    wb_finish("wr_byte1");

    // No selects: no request, ack in the cycle after stb is sampled.
    base = n_req;
    push_rsp(1'b0, 32'h5678_1234);
    wb_start(1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'b0000);
    wb_finish("sel_none");
    check("sel_none_ack_latency", last_ack_cyc - stb_cyc, 1);
    check("sel_none_nreq", n_req - base, 0);

    // High-half-only read: skipped low half reads back as 0.
    rd_q.push_back(16'h9ABC);
    push_req(1'b0, 32'h21, 16'h0, 2'b00, 1'b0);
    push_rsp(1'b0, 32'h9ABC_0000);
    wb_start(1'b0, 32'h0000_0040, 32'h0, 4'b1100);
    wb_finish("rd_hi_only");

    // Controller not ready for 20 cycles: request appears in the cycle ready rises.
    hold_ready = 1'b1;
    base = n_req;
    push_req(1'b1, 32'h28, 16'h2222, 2'b00, 1'b0);
    push_rsp(1'b0, 32'h9ABC_0000);
    wb_start(1'b1, 32'h0000_0050, 32'h1111_2222, 4'b0011);
    repeat (20) @(posedge clk);
    check("ready_low_nreq", n_req - base, 0);
    #1;
    hold_ready = 1'b0;
    rise_cyc = cyc_n;
    wb_finish("ready_hold");
    check("ready_rise_req_latency", last_req_cyc - rise_cyc, 0);

    // Asynchronous reset while waiting on the high half.
    withhold_after = 1;
    base = n_req;
    base_ack = n_ack;
    push_req(1'b1, 32'h30, 16'h4444, 2'b00, 1'b0);
    push_req(1'b1, 32'h31, 16'h3333, 2'b00, 1'b0);
    wb_start(1'b1, 32'h0000_0060, 32'h3333_4444, 4'b1111);
    wait_reqs(base + 2, "rst_mid");
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    withhold_after = -1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_no_ack", n_ack - base_ack, 0);

    // Access after reset works; low-half read.
    rd_q.push_back(16'h0F0F);
    push_req(1'b0, 32'h38, 16'h0, 2'b00, 1'b0);
    push_rsp(1'b0, 32'h0000_0F0F);
    wb_start(1'b0, 32'h0000_0070, 32'h0, 4'b0011);
    wb_finish("rd_after_rst");

    // cyc dropped during WAIT_LO: high half still issued, ack suppressed.
    ctrl_lat = 4;
    base = n_req;
    base_ack = n_ack;
    push_req(1'b1, 32'h40, 16'h6666, 2'b00, 1'b0);
    push_req(1'b1, 32'h41, 16'h5555, 2'b00, 1'b0);
    wb_start(1'b1, 32'h0000_0080, 32'h5555_6666, 4'b1111);
    wait_reqs(base + 1, "cyc_drop_lo");
    @(posedge clk); #1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wait_reqs(base + 2, "cyc_drop_hi");
    repeat (10) @(posedge clk);
    check("cyc_drop_no_ack", n_ack - base_ack, 0);
    ctrl_lat = 0;

    base_ack = n_ack;
    base_err = n_err;
`ifdef HBUS_BRIDGE_TIMEOUT_EN
    // Withheld valid: error 16 cycles after the request, no ack.
    withhold_after = 0;
    push_req(1'b1, 32'h48, 16'h7777, 2'b00, 1'b0);
    push_rsp(1'b1, 32'h0);
    wb_start(1'b1, 32'h0000_0090, 32'h0000_7777, 4'b0011);
    wb_finish("timeout");
    check("timeout_err_latency", last_err_cyc - last_req_cyc, 16);
    check("timeout_nerr", n_err - base_err, 1);
    check("timeout_no_ack", n_ack - base_ack, 0);
    withhold_after = -1;
    @(posedge clk); #1;
`else
    // Withheld valid without the timeout feature: the bridge keeps waiting silently.
    withhold_after = 0;
    push_req(1'b1, 32'h48, 16'h7777, 2'b00, 1'b0);
    wb_start(1'b1, 32'h0000_0090, 32'h0000_7777, 4'b0011);
    repeat (40) @(posedge clk);
    check("no_timeout_nerr", n_err - base_err, 0);
    check("no_timeout_no_ack", n_ack - base_ack, 0);
    #1;
    rst = 1'b1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    withhold_after = -1;
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    // Bridge is back in IDLE and serves a full read.
    rd_q.push_back(16'hAAAA);
    rd_q.push_back(16'hBBBB);
    push_req(1'b0, 32'h50, 16'h0, 2'b00, 1'b0);
    push_req(1'b0, 32'h51, 16'h0, 2'b00, 1'b0);
    push_rsp(1'b0, 32'hBBBB_AAAA);
    wb_start(1'b0, 32'h0000_00A0, 32'h0, 4'b1111);
    wb_finish("rd_final");

    repeat (3) @(posedge clk);
    check("req_queue_empty", exp_req_q.size(), 0);
    check("rsp_queue_empty", exp_rsp_q.size(), 0);
    check("rd_queue_empty", rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
